// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   Byte echo engine placed between a UART receiver and transmitter. Every
//   received byte is optionally case-folded and queued in a FIFO; a small TX
//   state machine replays the queue to the transmitter one byte at a time,
//   optionally following each CR (0x0D) with an inserted LF (0x0A).
//
// Ports
//   CLK       in   1                system clock, all logic on the rising edge
//   reset     in   1                synchronous, active-high
//   rx_done   in   1                one-cycle strobe: rx_data is valid
//   rx_data   in   DATA_W           received byte
//   tx_rdy    in   1                transmitter idle (1) / busy (0)
//   tx_send   out  1                send request, held until tx_rdy drops
//   tx_data   out  DATA_W           byte to transmit, stable while tx_send=1
//   fill      out  clog2(DEPTH+1)   entries currently queued
//   overflow  out  1                sticky: at least one byte was dropped
//   drop_cnt  out  8                dropped byte count, saturates at 255
//   led       out  2                {overflow, tx_send}
module uart_echo_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int CASE_MODE = 0,
  parameter int LF_EXPAND = 1
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       tx_rdy,
  output logic                       tx_send,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [1:0]                 led
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [DATA_W-1:0] C_CR = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] C_LF = DATA_W'(8'h0A);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_LF_WAIT = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [FW-1:0]     r_fill;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;
  logic              r_tx_send;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_lf_ins;   // byte in SEND is an inserted LF, never re-expanded
  state_t            r_state;

  logic [DATA_W-1:0] w_wr_byte;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  // Case folding applies to 8-bit ASCII only; any other width passes through.
  generate
    if (DATA_W == 8 && CASE_MODE == 1) begin : g_upper
      assign w_wr_byte = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
    end else if (DATA_W == 8 && CASE_MODE == 2) begin : g_lower
      assign w_wr_byte = (rx_data >= 8'h41 && rx_data <= 8'h5A) ? rx_data + 8'h20 : rx_data;
    end else begin : g_raw
      assign w_wr_byte = rx_data;
    end
  endgenerate

  assign w_full = (r_fill == FW'(DEPTH));
  // Only IDLE pops, so a single byte is ever in flight toward the transmitter.
  assign w_pop  = (r_state == S_IDLE) && (r_fill != '0) && tx_rdy;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = rx_done && (!w_full || w_pop);

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
      if (rx_done && !w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  // TX handshake: raise send, wait for the transmitter to go busy (accept),
  // then optionally queue an LF after a CR without consuming a FIFO entry.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
      r_lf_ins  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_tx_send <= 1'b1;
            r_lf_ins  <= 1'b0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_rdy) begin
            r_tx_send <= 1'b0;
            if (LF_EXPAND != 0 && r_tx_data == C_CR && !r_lf_ins) begin
              r_state <= S_LF_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_LF_WAIT: begin
          if (tx_rdy) begin
            r_tx_data <= C_LF;
            r_tx_send <= 1'b1;
            r_lf_ins  <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_tx_send <= 1'b0;
        end
      endcase
    end
  end

  assign tx_send  = r_tx_send;
  assign tx_data  = r_tx_data;
  assign fill     = r_fill;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign led      = {r_overflow, r_tx_send};

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo
//   Exercises two instances: "A" (DEPTH 16, fold to upper, LF expansion on)
//   and "L" (DEPTH 4, fold to lower, no LF expansion). Transmitted bytes are
//   logged on every rising edge of tx_send and compared against a byte
//   stream derived from the folding / CR-LF rules.
module tb_uart_echo_fifo;

  logic       clk;
  logic       rst;

  logic       a_rx_done;
  logic [7:0] a_rx_data;
  logic       a_rdy;
  logic       a_send;
  logic [7:0] a_data;
  logic [4:0] a_fill;
  logic       a_ovf;
  logic [7:0] a_drop;
  logic [1:0] a_led;

  logic       l_rx_done;
  logic [7:0] l_rx_data;
  logic       l_rdy;
  logic       l_send;
  logic [7:0] l_data;
  logic [2:0] l_fill;
  logic       l_ovf;
  logic [7:0] l_drop;
  logic [1:0] l_led;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] got_a[$];
  logic [7:0] exp_a[$];
  int         gotfill_a[$];
  logic [7:0] got_l[$];

  logic a_send_prev = 1'b0;
  logic l_send_prev = 1'b0;
  bit   a_auto = 1'b0;
  bit   l_auto = 1'b0;
  int   a_busy = 0;
  int   l_busy = 0;

  uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .CASE_MODE(1), .LF_EXPAND(1)) u_a (
    .CLK(clk), .reset(rst), .rx_done(a_rx_done), .rx_data(a_rx_data),
    .tx_rdy(a_rdy), .tx_send(a_send), .tx_data(a_data), .fill(a_fill),
    .overflow(a_ovf), .drop_cnt(a_drop), .led(a_led)
  );

  uart_echo_fifo #(.DATA_W(8), .DEPTH(4), .CASE_MODE(2), .LF_EXPAND(0)) u_l (
    .CLK(clk), .reset(rst), .rx_done(l_rx_done), .rx_data(l_rx_data),
    .tx_rdy(l_rdy), .tx_send(l_send), .tx_data(l_data), .fill(l_fill),
    .overflow(l_ovf), .drop_cnt(l_drop), .led(l_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fold(input logic [7:0] b, input int mode);
    if (mode == 1 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    if (mode == 2 && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    return b;
  endfunction

  // One clock: sample 1 time unit after the edge, log sends, emulate the
  // transmitter (goes busy for a random time after seeing a request).
  task automatic step();
    @(posedge clk);
    #1;
    if (a_send && !a_send_prev) begin
      got_a.push_back(a_data);
      gotfill_a.push_back(int'(a_fill));
      $display("tx A byte 0x%02h fill %0d", a_data, a_fill);
    end
    a_send_prev = a_send;
    if (l_send && !l_send_prev) begin
      got_l.push_back(l_data);
      $display("tx L byte 0x%02h fill %0d", l_data, l_fill);
    end
    l_send_prev = l_send;
    if (a_auto) begin
      if (a_busy > 0) begin
        a_busy--;
        if (a_busy == 0) a_rdy = 1'b1;
      end else if (a_send && a_rdy) begin
        a_rdy  = 1'b0;
        a_busy = $urandom_range(1, 5);
      end
    end
    if (l_auto) begin
      if (l_busy > 0) begin
        l_busy--;
        if (l_busy == 0) l_rdy = 1'b1;
      end else if (l_send && l_rdy) begin
        l_rdy  = 1'b0;
        l_busy = $urandom_range(1, 5);
      end
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    a_rx_done = 1'b1;
    a_rx_data = b;
    step();
    a_rx_done = 1'b0;
  endtask

  task automatic push_l(input logic [7:0] b);
    l_rx_done = 1'b1;
    l_rx_data = b;
    step();
    l_rx_done = 1'b0;
  endtask

  task automatic clear_a();
    got_a.delete();
    exp_a.delete();
    gotfill_a.delete();
  endtask

  // Run A's transmitter until the expected stream has left, then compare.
  task automatic drain_a(input string name, input int budget);
    int n;
    n = 0;
    while (!(a_fill == 5'd0 && a_send == 1'b0 && got_a.size() >= exp_a.size()) && n < budget) begin
      step();
      n++;
    end
    for (int i = 0; i < 20; i++) step();
    total_cnt++;
    if (n >= budget) $display("FAIL %s_timeout: still busy after %0d cycles, fill=%0d", name, n, a_fill);
    else pass_cnt++;
    total_cnt++;
    if (got_a.size() != exp_a.size())
      $display("FAIL %s_count: sent %0d bytes, required %0d", name, got_a.size(), exp_a.size());
    else pass_cnt++;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      total_cnt++;
      if (got_a[i] !== exp_a[i])
        $display("FAIL %s_byte%0d: got 0x%02h required 0x%02h", name, i, got_a[i], exp_a[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total_cnt++; if (a_send !== 1'b0) $display("FAIL reset_send: got %b required 0", a_send); else pass_cnt++;
    total_cnt++; if (a_data !== 8'h00) $display("FAIL reset_data: got 0x%02h required 0x00", a_data); else pass_cnt++;
    total_cnt++; if (a_fill !== 5'd0) $display("FAIL reset_fill: got %0d required 0", a_fill); else pass_cnt++;
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf: got %b required 0", a_ovf); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd0) $display("FAIL reset_drop: got %0d required 0", a_drop); else pass_cnt++;
    total_cnt++; if (a_led !== 2'b00) $display("FAIL reset_led: got %b required 00", a_led); else pass_cnt++;
    total_cnt++; if (l_fill !== 3'd0) $display("FAIL reset_l_fill: got %0d required 0", l_fill); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_a();
    a_auto = 1'b0;
    a_rdy  = 1'b1;
    step();
    push_a(8'h41);
    total_cnt++; if (a_fill !== 5'd1) $display("FAIL single_fill1: got %0d required 1", a_fill); else pass_cnt++;
    total_cnt++; if (a_send !== 1'b0) $display("FAIL single_early: got %b required 0", a_send); else pass_cnt++;
    step();
    total_cnt++; if (a_send !== 1'b1) $display("FAIL single_send: got %b required 1", a_send); else pass_cnt++;
    total_cnt++; if (a_data !== 8'h41) $display("FAIL single_data: got 0x%02h required 0x41", a_data); else pass_cnt++;
    total_cnt++; if (a_led[0] !== 1'b1) $display("FAIL single_led0: got %b required 1", a_led[0]); else pass_cnt++;
    a_rdy = 1'b0;
    step();
    total_cnt++; if (a_send !== 1'b0) $display("FAIL single_drop: got %b required 0", a_send); else pass_cnt++;
    total_cnt++; if (a_fill !== 5'd0) $display("FAIL single_fill0: got %0d required 0", a_fill); else pass_cnt++;
    a_rdy = 1'b1;
    step();
    clear_a();
  endtask

  task automatic test_burst_overflow();
    clear_a();
    a_auto = 1'b0;
    a_rdy  = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      push_a(8'(i));
      exp_a.push_back(fold(8'(i), 1));
      if (fold(8'(i), 1) == 8'h0D) exp_a.push_back(8'h0A);
    end
    total_cnt++; if (a_fill !== 5'd16) $display("FAIL burst_fill: got %0d required 16", a_fill); else pass_cnt++;
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL burst_ovf: got %b required 0", a_ovf); else pass_cnt++;
    // these three must be lost
    push_a(8'h70);
    push_a(8'h71);
    push_a(8'h72);
    total_cnt++; if (a_ovf !== 1'b1) $display("FAIL ovf_flag: got %b required 1", a_ovf); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd3) $display("FAIL ovf_drop: got %0d required 3", a_drop); else pass_cnt++;
    total_cnt++; if (a_led[1] !== 1'b1) $display("FAIL ovf_led1: got %b required 1", a_led[1]); else pass_cnt++;
    total_cnt++; if (a_fill !== 5'd16) $display("FAIL ovf_fill: got %0d required 16", a_fill); else pass_cnt++;
    // full + push + pop in one cycle
    a_rdy = 1'b1;
    push_a(8'hAA);
    exp_a.push_back(fold(8'hAA, 1));
    total_cnt++; if (a_fill !== 5'd16) $display("FAIL fullpp_fill: got %0d required 16", a_fill); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd3) $display("FAIL fullpp_drop: got %0d required 3", a_drop); else pass_cnt++;
    total_cnt++; if (a_data !== 8'h00) $display("FAIL fullpp_head: got 0x%02h required 0x00", a_data); else pass_cnt++;
    a_busy = 0;
    a_auto = 1'b1;
    drain_a("burst", 2000);
    a_auto = 1'b0;
    a_rdy  = 1'b1;
    clear_a();
  endtask

  task automatic test_lf();
    clear_a();
    a_auto = 1'b0;
    a_rdy  = 1'b0;
    step();
    push_a(8'h0D);
    push_a(8'h42);
    total_cnt++; if (a_fill !== 5'd2) $display("FAIL lf_fill: got %0d required 2", a_fill); else pass_cnt++;
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
    exp_a.push_back(8'h42);
    a_rdy  = 1'b1;
    a_busy = 0;
    a_auto = 1'b1;
    drain_a("lf", 500);
    // fill seen as each byte goes out: the inserted LF must not consume an entry
    if (gotfill_a.size() == 3) begin
      total_cnt++; if (gotfill_a[0] != 1) $display("FAIL lf_pop_cr: fill %0d required 1", gotfill_a[0]); else pass_cnt++;
      total_cnt++; if (gotfill_a[1] != 1) $display("FAIL lf_pop_lf: fill %0d required 1", gotfill_a[1]); else pass_cnt++;
      total_cnt++; if (gotfill_a[2] != 0) $display("FAIL lf_pop_b: fill %0d required 0", gotfill_a[2]); else pass_cnt++;
    end
    clear_a();
    push_a(8'h0A);
    exp_a.push_back(8'h0A);
    drain_a("lf_alone", 500);
    clear_a();
  endtask

  task automatic test_case();
    int n;
    clear_a();
    push_a(8'h61);
    push_a(8'h5A);
    push_a(8'h7B);
    exp_a.push_back(8'h41);
    exp_a.push_back(8'h5A);
    exp_a.push_back(8'h7B);
    drain_a("case_upper", 500);
    clear_a();
    // lower-folding instance
    got_l.delete();
    l_rdy  = 1'b1;
    l_busy = 0;
    l_auto = 1'b1;
    push_l(8'h41);
    push_l(8'h61);
    push_l(8'h5B);
    n = 0;
    while (!(l_fill == 3'd0 && l_send == 1'b0 && got_l.size() >= 3) && n < 500) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) step();
    total_cnt++;
    if (got_l.size() != 3) $display("FAIL case_lower_count: sent %0d bytes, required 3", got_l.size());
    else pass_cnt++;
    if (got_l.size() == 3) begin
      total_cnt++; if (got_l[0] !== 8'h61) $display("FAIL case_lower0: got 0x%02h required 0x61", got_l[0]); else pass_cnt++;
      total_cnt++; if (got_l[1] !== 8'h61) $display("FAIL case_lower1: got 0x%02h required 0x61", got_l[1]); else pass_cnt++;
      total_cnt++; if (got_l[2] !== 8'h5B) $display("FAIL case_lower2: got 0x%02h required 0x5B", got_l[2]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_send();
    bit seen;
    clear_a();
    a_auto = 1'b0;
    a_busy = 0;
    a_rdy  = 1'b1;
    step();
    for (int i = 1; i <= 6; i++) push_a(8'(i));
    total_cnt++; if (a_send !== 1'b1) $display("FAIL rsend_pre_send: got %b required 1", a_send); else pass_cnt++;
    total_cnt++; if (a_fill !== 5'd5) $display("FAIL rsend_pre_fill: got %0d required 5", a_fill); else pass_cnt++;
    rst   = 1'b1;
    a_rdy = 1'b0;
    step();
    rst = 1'b0;
    total_cnt++; if (a_send !== 1'b0) $display("FAIL rsend_send: got %b required 0", a_send); else pass_cnt++;
    total_cnt++; if (a_fill !== 5'd0) $display("FAIL rsend_fill: got %0d required 0", a_fill); else pass_cnt++;
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL rsend_ovf: got %b required 0", a_ovf); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd0) $display("FAIL rsend_drop: got %0d required 0", a_drop); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_send) seen = 1'b1;
    end
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_send) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rsend_quiet: send seen %b required 0", seen); else pass_cnt++;
    push_a(8'h33);
    step();
    total_cnt++; if (a_send !== 1'b1) $display("FAIL rsend_new_send: got %b required 1", a_send); else pass_cnt++;
    total_cnt++; if (a_data !== 8'h33) $display("FAIL rsend_new_data: got 0x%02h required 0x33", a_data); else pass_cnt++;
    a_rdy = 1'b0;
    step();
    a_rdy = 1'b1;
    step();
    clear_a();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int len;
    a_auto = 1'b0;
    a_rdy  = 1'b1;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    a_busy = 0;
    a_auto = 1'b1;
    for (int r = 0; r < 12; r++) begin
      clear_a();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       b = 8'h0D;
          1:       b = 8'($urandom_range(8'h41, 8'h7A));
          default: b = 8'($urandom_range(0, 255));
        endcase
        push_a(b);
        exp_a.push_back(fold(b, 1));
        if (fold(b, 1) == 8'h0D) exp_a.push_back(8'h0A);
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
      end
      drain_a($sformatf("rand%0d", r), 2000);
    end
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL rand_ovf: got %b required 0", a_ovf); else pass_cnt++;
    total_cnt++; if (a_drop !== 8'd0) $display("FAIL rand_drop: got %0d required 0", a_drop); else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    a_rx_done = 1'b0;
    a_rx_data = 8'h00;
    a_rdy     = 1'b1;
    l_rx_done = 1'b0;
    l_rx_data = 8'h00;
    l_rdy     = 1'b1;
    test_reset();
    test_single();
    test_burst_overflow();
    test_lf();
    test_case();
    test_reset_send();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
